// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between writeback, load return and debug.
// Define REGFILE_CLEAR_EN to add the clr_start/clr_busy/clr_done x1..x31 clear sequencer.
module regfile_write_arbiter #(
  parameter int NREG  = 32,
  parameter int CNT_W = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [AW-1:0]    wb_addr,
  input  logic [31:0]      wb_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [31:0]      ld_data,
  input  logic             dbg_valid,
  output logic             dbg_ready,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [31:0]      dbg_data,
  output logic             WriteEnable3,
  output logic [AW-1:0]    Address3,
  output logic [31:0]      WD3,
`ifdef REGFILE_CLEAR_EN
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
`endif
  output logic [CNT_W-1:0] contention_cnt
);

  logic [1:0]    rr_ptr;
  logic [1:0]    ptr_next;
  logic [2:0]    req;
  logic [2:0]    grant;
  logic          arb_en;
  logic          accept;
  logic          multi;
  logic          issue_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_data;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t    state;
  logic [AW-1:0] idx;

  // A clear request pre-empts any grant in the cycle it is raised.
  assign arb_en = rst && (state == IDLE) && !clr_start;
`else
  assign arb_en = rst;
`endif

  assign req   = arb_en ? {dbg_valid, ld_valid, wb_valid} : 3'b000;
  assign multi = (wb_valid & ld_valid) | (wb_valid & dbg_valid) | (ld_valid & dbg_valid);

  // Search for the first pending requester starting at rr_ptr, wrapping modulo 3.
  always_comb begin
    grant = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (req[1])      grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      2'd2: begin
        if (req[2])      grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if (req[0])      grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_next = rr_ptr;
    sel_addr = wb_addr;
    sel_data = wb_data;
    if (grant[0]) ptr_next = 2'd1;
    if (grant[1]) begin
      ptr_next = 2'd2;
      sel_addr = ld_addr;
      sel_data = ld_data;
    end
    if (grant[2]) begin
      ptr_next = 2'd0;
      sel_addr = dbg_addr;
      sel_data = dbg_data;
    end
  end

  assign wb_ready  = grant[0];
  assign ld_ready  = grant[1];
  assign dbg_ready = grant[2];
  assign accept    = |grant;
  assign issue_we  = accept && (sel_addr != '0);

  // Writes to x0 are consumed without touching the register file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr         <= 2'd0;
      contention_cnt <= '0;
      WriteEnable3   <= 1'b0;
      Address3       <= '0;
      WD3            <= '0;
`ifdef REGFILE_CLEAR_EN
      state          <= IDLE;
      idx            <= '0;
      clr_busy       <= 1'b0;
      clr_done       <= 1'b0;
`endif
    end else begin
      if (multi && (contention_cnt != '1))
        contention_cnt <= contention_cnt + 1'b1;
      if (accept)
        rr_ptr <= ptr_next;
`ifdef REGFILE_CLEAR_EN
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state        <= CLEAR;
            idx          <= AW'(1);
            clr_busy     <= 1'b1;
            WriteEnable3 <= 1'b1;
            Address3     <= AW'(1);
            WD3          <= '0;
          end else begin
            WriteEnable3 <= issue_we;
            if (issue_we) begin
              Address3 <= sel_addr;
              WD3      <= sel_data;
            end
          end
        end
        CLEAR: begin
          if (idx == AW'(NREG - 1)) begin
            state        <= IDLE;
            clr_busy     <= 1'b0;
            clr_done     <= 1'b1;
            WriteEnable3 <= 1'b0;
          end else begin
            idx          <= idx + 1'b1;
            WriteEnable3 <= 1'b1;
            Address3     <= idx + 1'b1;
            WD3          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
`else
      WriteEnable3 <= issue_we;
      if (issue_we) begin
        Address3 <= sel_addr;
        WD3      <= sel_data;
      end
`endif
    end
  end

endmodule
